// File: rtl/i3c_tgt_sdr_ccc_responder.sv
// I3C target SDR front end: START/Sr/STOP detection, broadcast-address ACK,
// CCC byte capture with odd-parity T-bit check, ENTHDRx entry and HDR Exit detection.
//
// state     | meaning
// IDLE      | bus free or target disabled; waiting for START
// ADDR      | shifting the 8-bit address byte
// ACK_SETUP | broadcast/W matched; waiting for the 8th-bit SCL fall
// ACK       | pulling SDA low through the 9th SCL period
// CCC       | shifting 8 CCC bits plus the T-bit
// WAIT_STOP | ignoring bits until STOP or Sr
// HDR       | in HDR mode; only watching for the HDR Exit pattern
module i3c_tgt_sdr_ccc_responder #(
  parameter logic [6:0] BCAST_ADDR  = 7'h7E,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_sdr_clk,
  input  logic       i_sdr_rst_n,
  input  logic       i_tgt_en,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  output logic       o_ccc_valid,
  output logic [7:0] o_ccc_code,
  output logic       o_parity_err,
  output logic       o_enthdr,
  output logic       o_hdr_mode,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_SETUP, ACK, CCC, WAIT_STOP, HDR
  } state_t;

  state_t state, state_d;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_prev, sda_prev;
  logic scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
  logic [3:0] cnt, cnt_d;
  logic [7:0] sr, sr_d;
  logic ccc_ok_q, ccc_ok_d, par_bad_q, par_bad_d, enthdr_q, enthdr_d;
  logic sda_low_o, ccc_valid_o, parity_err_o, enthdr_o, hdr_mode_o, busy_o;
  logic [7:0] ccc_code_o;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign sda_rise = sda_s & ~sda_prev;
  assign sda_fall = ~sda_s & sda_prev;
  // SCL must be stably high across the SDA edge to count as a bus condition
  assign start    = sda_fall & scl_s & scl_prev;
  assign stop     = sda_rise & scl_s & scl_prev;

  always_ff @(posedge i_sdr_clk) begin
    if (!i_sdr_rst_n) begin
      scl_sync     <= '1;
      sda_sync     <= '1;
      scl_prev     <= 1'b1;
      sda_prev     <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      ccc_ok_q     <= 1'b0;
      par_bad_q    <= 1'b0;
      enthdr_q     <= 1'b0;
      o_sda_low    <= 1'b0;
      o_ccc_valid  <= 1'b0;
      o_ccc_code   <= '0;
      o_parity_err <= 1'b0;
      o_enthdr     <= 1'b0;
      o_hdr_mode   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      scl_sync     <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync     <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_prev     <= scl_s;
      sda_prev     <= sda_s;
      state        <= state_d;
      cnt          <= cnt_d;
      sr           <= sr_d;
      ccc_ok_q     <= ccc_ok_d;
      par_bad_q    <= par_bad_d;
      enthdr_q     <= enthdr_d;
      o_sda_low    <= sda_low_o;
      o_ccc_valid  <= ccc_valid_o;
      o_ccc_code   <= ccc_code_o;
      o_parity_err <= parity_err_o;
      o_enthdr     <= enthdr_o;
      o_hdr_mode   <= hdr_mode_o;
      o_busy       <= busy_o;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    sr_d      = sr;
    ccc_ok_d  = 1'b0;
    par_bad_d = 1'b0;
    enthdr_d  = 1'b0;
    if (!i_tgt_en && state != HDR) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        WAIT_STOP: begin
          if (stop) begin
            state_d = IDLE;
          end else if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        HDR: begin
          // Exit pattern: four SDA falls with no intervening SCL rise
          if (scl_rise) begin
            cnt_d = '0;
          end else if (sda_fall && !scl_s) begin
            if (cnt == 4'd3) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end
        end
        default: begin
          if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
          end else if (state == ADDR && scl_rise) begin
            sr_d = {sr[6:0], sda_s};
            if (cnt == 4'd7) begin
              cnt_d   = '0;
              state_d = ({sr[6:0], sda_s} == {BCAST_ADDR, 1'b0}) ? ACK_SETUP : WAIT_STOP;
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end else if (state == ACK_SETUP && scl_fall) begin
            state_d = ACK;
          end else if (state == ACK && scl_fall) begin
            state_d = CCC;
            cnt_d   = '0;
          end else if (state == CCC && scl_rise) begin
            if (cnt == 4'd8) begin
              cnt_d = '0;
              if (sda_s == ~^sr) begin
                ccc_ok_d = 1'b1;
                if (sr[7:3] == 5'b00100) begin
                  enthdr_d = 1'b1;
                  state_d  = HDR;
                end else begin
                  state_d = WAIT_STOP;
                end
              end else begin
                par_bad_d = 1'b1;
                state_d   = WAIT_STOP;
              end
            end else begin
              sr_d  = {sr[6:0], sda_s};
              cnt_d = cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    sda_low_o    = (state == ACK) && i_tgt_en;
    ccc_valid_o  = ccc_ok_q;
    ccc_code_o   = ccc_ok_q ? sr : o_ccc_code;
    parity_err_o = par_bad_q;
    enthdr_o     = enthdr_q;
    hdr_mode_o   = (state == HDR);
    busy_o       = (state != IDLE);
  end

endmodule

// File: tb/tb_i3c_tgt_sdr_ccc_responder.sv
// Directed bench for the I3C target SDR CCC responder: drives SCL/SDA with a
// wired-AND SDA model and compares outputs against hand-computed values.
module tb_i3c_tgt_sdr_ccc_responder;

  localparam int PH = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tgt_en, scl, sda_drv;
  logic sda_low, ccc_valid, parity_err, enthdr, hdr_mode, busy;
  logic [7:0] ccc_code;
  wire sda_pin = sda_drv & ~sda_low;

  i3c_tgt_sdr_ccc_responder #(.BCAST_ADDR(7'h7E), .SYNC_STAGES(2)) dut (
    .i_sdr_clk    (clk),
    .i_sdr_rst_n  (rst_n),
    .i_tgt_en     (tgt_en),
    .i_scl        (scl),
    .i_sda        (sda_pin),
    .o_sda_low    (sda_low),
    .o_ccc_valid  (ccc_valid),
    .o_ccc_code   (ccc_code),
    .o_parity_err (parity_err),
    .o_enthdr     (enthdr),
    .o_hdr_mode   (hdr_mode),
    .o_busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  int n_valid = 0, n_enthdr = 0, n_perr = 0, n_low = 0, n_sync_err = 0;
  logic [7:0] last_code = 8'h00;
  logic hdr_prev = 1'b0;
  always @(negedge clk) begin
    if (ccc_valid) begin
      n_valid++;
      last_code = ccc_code;
    end
    if (enthdr) n_enthdr++;
    if (parity_err) n_perr++;
    if (sda_low) n_low++;
    if (enthdr && !hdr_mode) n_sync_err++;
    if (hdr_mode && !hdr_prev && !enthdr) n_sync_err++;
    hdr_prev = hdr_mode;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    sda_drv = 1'b1; tick(PH/2);
    scl = 1'b1;     tick(PH);
    sda_drv = 1'b0; tick(PH);
    scl = 1'b0;     tick(PH/2);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; tick(PH/2);
    scl = 1'b1;     tick(PH);
    sda_drv = 1'b1; tick(PH);
  endtask

  task automatic send_bit(input logic b, output logic low, output logic pin);
    sda_drv = b; tick(PH/2);
    scl = 1'b1;  tick(PH/2);
    low = sda_low;
    pin = sda_pin;
    tick(PH/2);
    scl = 1'b0;  tick(PH/2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic lo8, output logic lo9, output logic pin9);
    logic l, p;
    for (int i = 7; i >= 0; i--) send_bit(b[i], l, p);
    lo8 = l;
    send_bit(1'b1, lo9, pin9);
  endtask

  task automatic send_ccc(input logic [7:0] b, input logic t, output logic lo_first);
    logic l, p;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], l, p);
      if (i == 7) lo_first = l;
    end
    send_bit(t, l, p);
  endtask

  task automatic hdr_falls(input int n);
    for (int i = 0; i < n; i++) begin
      sda_drv = 1'b1; tick(6);
      sda_drv = 1'b0; tick(6);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic lo8, lo9, p9, lf, l, p;
    int bv, be, bp, bl;
    rst_n = 1'b0; tgt_en = 1'b1; scl = 1'b1; sda_drv = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(3);
    check("rst_sda_low", sda_low, 0);
    check("rst_busy", busy, 0);
    check("rst_hdr", hdr_mode, 0);
    check("rst_code", ccc_code, 8'h00);
    check("rst_valid", ccc_valid, 0);

    // ENTHDR0 with good parity
    bv = n_valid; be = n_enthdr; bp = n_perr; bl = n_low;
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    check("t1_lo_bit8", lo8, 0);
    check("t1_ack_drv", lo9, 1);
    check("t1_ack_pin", p9, 0);
    send_ccc(8'h20, 1'b0, lf);
    check("t1_ack_release", lf, 0);
    tick(6);
    check("t1_ack_width", n_low - bl, 20);
    check("t1_valid", n_valid - bv, 1);
    check("t1_code_pulse", last_code, 8'h20);
    check("t1_code", ccc_code, 8'h20);
    check("t1_enthdr", n_enthdr - be, 1);
    check("t1_perr", n_perr - bp, 0);
    check("t1_hdr_mode", hdr_mode, 1);
    check("t1_hdr_sync", n_sync_err, 0);

    // HDR exit: 3 falls interrupted by SCL rise, then 4 falls
    hdr_falls(3);
    scl = 1'b1; tick(6);
    scl = 1'b0; tick(6);
    check("hdr_hold", hdr_mode, 1);
    check("hdr_busy", busy, 1);
    hdr_falls(4);
    tick(6);
    check("hdr_exit", hdr_mode, 0);
    check("hdr_idle", busy, 0);
    stop_cond();

    // Non-ENTHDR CCC then STOP
    bv = n_valid; be = n_enthdr;
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    check("t2_ack", lo9, 1);
    send_ccc(8'h01, 1'b0, lf);
    tick(6);
    check("t2_valid", n_valid - bv, 1);
    check("t2_code", ccc_code, 8'h01);
    check("t2_enthdr", n_enthdr - be, 0);
    check("t2_hdr_mode", hdr_mode, 0);
    check("t2_wait_stop", busy, 1);
    stop_cond();
    tick(6);
    check("t2_idle", busy, 0);

    // Bad parity
    bv = n_valid; be = n_enthdr; bp = n_perr;
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    send_ccc(8'h20, 1'b1, lf);
    tick(6);
    check("t3_perr", n_perr - bp, 1);
    check("t3_valid", n_valid - bv, 0);
    check("t3_enthdr", n_enthdr - be, 0);
    check("t3_code_held", ccc_code, 8'h01);
    check("t3_hdr_mode", hdr_mode, 0);
    check("t3_wait_stop", busy, 1);
    stop_cond();
    tick(6);
    check("t3_idle", busy, 0);

    // Non-broadcast and 7E/R are never ACKed; Sr + 7E/W is
    bl = n_low; bv = n_valid;
    start_cond();
    send_byte(8'hA4, lo8, lo9, p9);
    start_cond();
    send_byte(8'hFD, lo8, lo9, p9);
    check("t4_no_ack", n_low - bl, 0);
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    check("t4_sr_ack", lo9, 1);
    send_ccc(8'h01, 1'b0, lf);
    tick(6);
    check("t4_valid", n_valid - bv, 1);
    stop_cond();

    // Reset asserted in the middle of the ACK bit
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(((8'hFC >> i) & 1) != 0, l, p);
    sda_drv = 1'b1; tick(PH/2);
    scl = 1'b1;     tick(3);
    check("t5_pre_rst_ack", sda_low, 1);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_sda_low", sda_low, 0);
    check("t5_rst_idle", busy, 0);
    check("t5_rst_code", ccc_code, 8'h00);
    rst_n = 1'b1;
    tick(2);
    scl = 1'b0; tick(PH/2);
    stop_cond();
    tick(6);
    check("t5_stay_idle", busy, 0);

    // Sr in the middle of the CCC byte restarts address decoding
    bv = n_valid;
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    send_bit(1'b1, l, p);
    send_bit(1'b0, l, p);
    send_bit(1'b1, l, p);
    send_bit(1'b0, l, p);
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    check("t6_sr_ack", lo9, 1);
    send_ccc(8'h07, 1'b0, lf);
    tick(6);
    check("t6_valid", n_valid - bv, 1);
    check("t6_code", ccc_code, 8'h07);
    stop_cond();

    // Target disabled: never ACK, stay idle
    tgt_en = 1'b0;
    bl = n_low;
    start_cond();
    send_byte(8'hFC, lo8, lo9, p9);
    check("t7_dis_no_ack", n_low - bl, 0);
    check("t7_dis_idle", busy, 0);
    stop_cond();
    tgt_en = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
